keyboard_decoder: RTL
=====================

KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: clock50 cycles allowed for scan_ready to clear after read asserts.
REQ-002 SHALL have port clock50  input  1  50 MHz system clock, sole clock; all state on posedge clock50.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port scan_ready  input  1  upstream byte-available flag; asynchronous to clock50.
REQ-005 SHALL have port scan_code  input  8  upstream PS/2 set-2 byte; stable while scan_ready=1.
REQ-006 SHALL have port read  output  1  acknowledge to upstream; a rising edge clears scan_ready.
REQ-007 SHALL have port action  output  6  one-hot, one-cycle game-action pulse: [0] up, [1] down, [2] left, [3] right, [4] reveal, [5] flag.
REQ-008 SHALL have port held  output  6  level, per-action key-currently-down, same bit order as action.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse per completed key event, any key.
REQ-010 SHALL have port key_code  output  8  final non-prefix byte of the last event.
REQ-011 SHALL have port key_ext  output  1  last event was E0-prefixed.
REQ-012 SHALL have port key_break  output  1  last event was F0-prefixed (release).
REQ-013 SHALL have port hs_error  output  1  sticky handshake-timeout flag.

Function
REQ-014 SHALL synchronize scan_ready through two clock50 flops (sync_ready) before any use.
REQ-015 SHALL run FSM IDLE -> ACK -> DECODE -> IDLE.
REQ-016 IDLE: on sync_ready=1, SHALL latch scan_code into code_q, set read=1, clear timeout counter, go ACK.
REQ-017 ACK: read held 1; on sync_ready=0, SHALL set read=0 and go DECODE; on counter reaching ACK_TIMEOUT, SHALL set read=0, set hs_error=1, discard code_q, go IDLE.
REQ-018 DECODE (exactly one cycle, then IDLE): code_q=E0 sets ext flag; code_q=F0 sets brk flag; no event for either.
REQ-019 DECODE, any other byte: SHALL pulse key_valid, load key_code/key_ext/key_break from code_q and flags, then clear both flags.
REQ-020 Action map: up=E0 75, down=E0 72, left=E0 6B, right=E0 74, reveal=29 or 5A (non-ext), flag=2B (non-ext); other codes map to no action.
REQ-021 Make of a mapped key with held bit 0 SHALL pulse action bit in the same cycle as key_valid and set held bit; make with held bit 1 (typematic repeat) SHALL set no action bit.
REQ-022 Break of a mapped key SHALL clear its held bit and pulse no action.
REQ-023 action SHALL have at most one bit set in any cycle, and be zero outside DECODE.
REQ-024 Latency: action/key_valid SHALL assert 1 cycle after the cycle sync_ready is first seen low in ACK.
REQ-025 Prefix order E0 F0 xx and F0 alone SHALL both be honoured; repeated prefixes are idempotent.
REQ-026 read SHALL never be 1 while FSM is in IDLE or DECODE.

Reset
REQ-027 On reset=1, SHALL asynchronously force: FSM IDLE, read=0, action=0, held=0, key_valid=0, key_code=00, key_ext=0, key_break=0, hs_error=0, prefix flags 0, sync flops 0.
REQ-028 Reset mid-ACK SHALL drop read immediately and discard the pending byte; upstream scan_ready is then re-acknowledged normally after release.
REQ-029 hs_error SHALL be cleared only by reset.

Structure
REQ-030 Package keyboard_pkg SHALL hold scan-code constants (E0, F0, 75, 72, 6B, 74, 29, 5A, 2B), action bit indices, FSM state encoding.
REQ-031 The two-flop synchronizer SHALL be a sub-module named sync_bit; all else in keyboard_decoder.

Verification
REQ-032 Byte 29 (make, scan_ready held until read) -> read rises, then one action=6'b010000 pulse, held[4]=1, key_code=29, key_ext=0, key_break=0.
REQ-033 Sequence E0 75, E0 75, E0 F0 75 -> action[0] pulses once only; held[0] 1 then 0; third event key_ext=1, key_break=1.
REQ-034 Byte 1C (unmapped) -> key_valid pulse, key_code=1C, action=0, held unchanged.
REQ-035 scan_ready stuck 1 for 300 cycles with ACK_TIMEOUT=255 -> read falls after 255 cycles, hs_error=1, no key_valid.
REQ-036 Reset asserted during ACK of byte 2B -> read=0 same cycle, all outputs at reset values, no action[5] pulse.
REQ-037 Prefix F0 then byte 2B without prior make -> key_valid, key_break=1, action=0, held[5] stays 0.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Scan-code constants, action bit indices and FSM encoding
// shared by the keyboard decoder and its synchronizer.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_REVEAL_A = 8'h29;
  localparam logic [7:0] SC_REVEAL_B = 8'h5A;
  localparam logic [7:0] SC_FLAG     = 8'h2B;

  localparam int ACT_UP     = 0;
  localparam int ACT_DOWN   = 1;
  localparam int ACT_LEFT   = 2;
  localparam int ACT_RIGHT  = 3;
  localparam int ACT_REVEAL = 4;
  localparam int ACT_FLAG   = 5;
  localparam int NUM_ACT    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACK    = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  // One-hot action mask for a final byte; zero when unmapped.
  function automatic logic [NUM_ACT-1:0] action_mask(
    input logic [7:0] code,
    input logic       ext
  );
    logic [NUM_ACT-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m[ACT_UP]    = 1'b1;
        SC_DOWN:  m[ACT_DOWN]  = 1'b1;
        SC_LEFT:  m[ACT_LEFT]  = 1'b1;
        SC_RIGHT: m[ACT_RIGHT] = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_REVEAL_A: m[ACT_REVEAL] = 1'b1;
        SC_REVEAL_B: m[ACT_REVEAL] = 1'b1;
        SC_FLAG:     m[ACT_FLAG]   = 1'b1;
        default:     m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst (async high), d (async in), q (synced out).
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 byte handshake and decode into game actions.
// Ports: clock50/reset, scan_ready/scan_code in, read ack out,
// action/held/key_* event outputs, sticky hs_error.
module keyboard_decoder
  import keyboard_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clock50,
  input  logic         reset,
  input  logic         scan_ready,
  input  logic [7:0]   scan_code,
  output logic         read,
  output logic [5:0]   action,
  output logic [5:0]   held,
  output logic         key_valid,
  output logic [7:0]   key_code,
  output logic         key_ext,
  output logic         key_break,
  output logic         hs_error
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic sync_ready;

  sync_bit u_sync (
    .clk (clock50),
    .rst (reset),
    .d   (scan_ready),
    .q   (sync_ready)
  );

  state_e        state_q, state_d;
  logic          read_q, read_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [5:0]    action_q, action_d;
  logic [5:0]    held_q, held_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d;
  logic          key_break_q, key_break_d;
  logic          hs_error_q, hs_error_d;
  logic [5:0]    mask;

  assign mask = action_mask(code_q, ext_q);

  // Decode is evaluated on the ACK->DECODE edge so the
  // registered pulses are visible exactly during DECODE.
  always_comb begin
    state_d     = state_q;
    read_d      = 1'b0;
    cnt_d       = cnt_q;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    action_d    = '0;
    held_d      = held_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    hs_error_d  = hs_error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync_ready) begin
          code_d  = scan_code;
          read_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!sync_ready) begin
          state_d = ST_DECODE;
          unique case (1'b1)
            (code_q == SC_EXT): ext_d = 1'b1;
            (code_q == SC_BRK): brk_d = 1'b1;
            default: begin
              key_valid_d = 1'b1;
              key_code_d  = code_q;
              key_ext_d   = ext_q;
              key_break_d = brk_q;
              ext_d       = 1'b0;
              brk_d       = 1'b0;
              if (brk_q) begin
                held_d = held_q & ~mask;
              end else begin
                // Typematic repeats find the bit held.
                action_d = mask & ~held_q;
                held_d   = held_q | mask;
              end
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          hs_error_d = 1'b1;
          code_d     = '0;
          state_d    = ST_IDLE;
        end else begin
          read_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      read_q      <= 1'b0;
      cnt_q       <= '0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      action_q    <= '0;
      held_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      hs_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      action_q    <= action_d;
      held_q      <= held_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      hs_error_q  <= hs_error_d;
    end
  end

  assign read      = read_q;
  assign action    = action_q;
  assign held      = held_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign hs_error  = hs_error_q;

endmodule
